prng_key_ctrl: RTL and testbench

Sequencer for the 32-bit PRNG key generator in the ChaCha20 datapath. It seeds the PRNG, steps it with single-cycle `new_key` pulses, and packs `WORDS` successive PRNG outputs into one wide key. It then presents that key to the ChaCha20 core through a valid/ack handshake. The block sits between the core's key-request logic and the PRNG instance, and is the only driver of the PRNG's `start`, `new_key` and `count_load` inputs.

---
 rtl/prng_key_ctrl.sv | 161 ++++++++++++++++
 tb/tb_prng_key_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/prng_key_ctrl.sv
// Key sequencer for the ChaCha20 PRNG: seeds the generator, steps it, and packs
// WORDS successive outputs into one wide key offered over a valid/ack handshake.
module prng_key_ctrl #(
    parameter int N     = 32,
    parameter int WORDS = 8,
    parameter int SKIP  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               rekey,
    input  logic [N-1:0]       seed_in,
    input  logic [N-1:0]       prng_key,
    input  logic               prng_ready,
    output logic               prng_start,
    output logic               prng_new_key,
    output logic [N-1:0]       prng_count_load,
    output logic [N*WORDS-1:0] key_out,
    output logic               key_valid,
    input  logic               key_ack,
    output logic               busy,
    output logic [7:0]         key_cnt
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SEED     = 3'd1;
    localparam logic [2:0] S_WAIT_RDY = 3'd2;
    localparam logic [2:0] S_STEP     = 3'd3;
    localparam logic [2:0] S_CAPTURE  = 3'd4;
    localparam logic [2:0] S_VALID    = 3'd5;

    logic [2:0]         state_q, state_d;
    logic               seeded_q, seeded_d;
    logic               req_pend_q, req_pend_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [SW-1:0]      skip_q, skip_d;
    logic [N*WORDS-1:0] key_q, key_d;
    logic               key_valid_q;
    logic               start_q;
    logic               new_key_q;
    logic [N-1:0]       count_load_q, count_load_d;
    logic               busy_q;
    logic [7:0]         key_cnt_q, key_cnt_d;
    logic               pend_eff;

    // A request arriving this cycle acts immediately, so IDLE leaves without
    // waiting a cycle for the pending flag to register.
    assign pend_eff = req_pend_q | (req & (state_q != S_VALID));

    always_comb begin
        state_d      = state_q;
        seeded_d     = seeded_q;
        req_pend_d   = pend_eff;
        idx_d        = idx_q;
        skip_d       = skip_q;
        key_d        = key_q;
        key_cnt_d    = key_cnt_q;
        count_load_d = count_load_q;

        case (state_q)
            S_IDLE: begin
                if (pend_eff) begin
                    state_d = seeded_q ? S_STEP : S_SEED;
                end
            end
            S_SEED: state_d = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (prng_ready) begin
                    seeded_d = 1'b1;
                    state_d  = pend_eff ? S_STEP : S_IDLE;
                end
            end
            S_STEP: state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (skip_q != SW'(SKIP)) begin
                    skip_d  = skip_q + 1'b1;
                    state_d = S_STEP;
                end else begin
                    for (int unsigned w = 0; w < WORDS; w++) begin
                        if (idx_q == IW'(w)) begin
                            key_d[w*N +: N] = prng_key;
                        end
                    end
                    skip_d = '0;
                    if (idx_q == IW'(WORDS - 1)) begin
                        idx_d      = '0;
                        req_pend_d = 1'b0;
                        state_d    = S_VALID;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_STEP;
                    end
                end
            end
            S_VALID: begin
                if (key_ack) begin
                    key_cnt_d = key_cnt_q + 8'd1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reseed abandons partial words but leaves key_out holding stale data.
        if (rekey) begin
            state_d    = S_SEED;
            seeded_d   = 1'b0;
            idx_d      = '0;
            skip_d     = '0;
            key_d      = key_q;
            key_cnt_d  = key_cnt_q;
            req_pend_d = req_pend_q | req;
        end

        if (state_d == S_SEED) begin
            count_load_d = (seed_in == '0) ? N'(1) : seed_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            seeded_q     <= 1'b0;
            req_pend_q   <= 1'b0;
            idx_q        <= '0;
            skip_q       <= '0;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            start_q      <= 1'b0;
            new_key_q    <= 1'b0;
            count_load_q <= '0;
            busy_q       <= 1'b0;
            key_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            seeded_q     <= seeded_d;
            req_pend_q   <= req_pend_d;
            idx_q        <= idx_d;
            skip_q       <= skip_d;
            key_q        <= key_d;
            key_valid_q  <= (state_d == S_VALID);
            start_q      <= (state_d == S_SEED);
            new_key_q    <= (state_d == S_STEP);
            count_load_q <= count_load_d;
            busy_q       <= (state_d != S_IDLE);
            key_cnt_q    <= key_cnt_d;
        end
    end

    assign prng_start      = start_q;
    assign prng_new_key    = new_key_q;
    assign prng_count_load = count_load_q;
    assign key_out         = key_q;
    assign key_valid       = key_valid_q;
    assign busy            = busy_q;
    assign key_cnt         = key_cnt_q;

endmodule

// File: tb/tb_prng_key_ctrl.sv
// Directed bench for prng_key_ctrl with a behavioural xorshift32 PRNG standing
// in for the generator; one instance at default SKIP, one at SKIP=1.
module tb_prng_key_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         req, rekey, key_ack;
    logic [31:0]  seed_in, prng_key;
    logic         prng_ready, prng_start, prng_new_key;
    logic [31:0]  prng_count_load;
    logic [255:0] key_out;
    logic         key_valid, busy;
    logic [7:0]   key_cnt;

    logic         req1, rekey1, key_ack1;
    logic [31:0]  seed_in1, prng_key1;
    logic         prng_ready1, prng_start1, prng_new_key1;
    logic [31:0]  prng_count_load1;
    logic [255:0] key_out1;
    logic         key_valid1, busy1;
    logic [7:0]   key_cnt1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    prng_key_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .rekey(rekey), .seed_in(seed_in),
        .prng_key(prng_key), .prng_ready(prng_ready), .prng_start(prng_start),
        .prng_new_key(prng_new_key), .prng_count_load(prng_count_load),
        .key_out(key_out), .key_valid(key_valid), .key_ack(key_ack),
        .busy(busy), .key_cnt(key_cnt)
    );

    prng_key_ctrl #(.N(32), .WORDS(8), .SKIP(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .rekey(rekey1), .seed_in(seed_in1),
        .prng_key(prng_key1), .prng_ready(prng_ready1), .prng_start(prng_start1),
        .prng_new_key(prng_new_key1), .prng_count_load(prng_count_load1),
        .key_out(key_out1), .key_valid(key_valid1), .key_ack(key_ack1),
        .busy(busy1), .key_cnt(key_cnt1)
    );

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] x;
        x = v;
        x ^= x << 13;
        x ^= x >> 17;
        x ^= x << 5;
        return x;
    endfunction

    function automatic logic [255:0] exp_key(input logic [31:0] seed, input int stride);
        logic [31:0]  x;
        logic [255:0] k;
        x = seed;
        k = '0;
        for (int w = 0; w < 8; w++) begin
            for (int s = 0; s < stride; s++) x = xs(x);
            k[w*32 +: 32] = x;
        end
        return k;
    endfunction

    // Generator model: loads on start, advances on new_key, ready after first start.
    always @(posedge clk) begin
        if (rst) begin
            prng_key <= '0; prng_ready <= 1'b0;
            prng_key1 <= '0; prng_ready1 <= 1'b0;
        end else begin
            if (prng_start) begin
                prng_key <= prng_count_load; prng_ready <= 1'b1;
            end else if (prng_new_key) begin
                prng_key <= xs(prng_key);
            end
            if (prng_start1) begin
                prng_key1 <= prng_count_load1; prng_ready1 <= 1'b1;
            end else if (prng_new_key1) begin
                prng_key1 <= xs(prng_key1);
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the current cycle with stimulus already driven; checks cycles 1..ncyc.
    task automatic watch(input int ncyc, input logic exp_start, input logic [31:0] cl,
                         input int first_step, input int last_step, input logic [255:0] prev);
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            req = 1'b0;
            rekey = 1'b0;
            chk("start", prng_start, exp_start && c == 1);
            chk("new_key", prng_new_key,
                c >= first_step && c <= last_step && ((c - first_step) % 2 == 0));
            chk("valid", key_valid, c == ncyc);
            chk("busy", busy, 1'b1);
            if (exp_start && c == 1) chk("count_load", prng_count_load, cl);
            if (c <= first_step + 1) chk("key_hold", key_out, prev);
        end
    endtask

    task automatic do_ack(input logic [7:0] exp_cnt);
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        chk("ack_valid", key_valid, 1'b0);
        chk("ack_busy", busy, 1'b0);
        chk("ack_cnt", key_cnt, exp_cnt);
    endtask

    initial begin
        logic [255:0] k1, k2, k3, k4, kpart, kstale;
        int pulses;

        rst = 1'b1;
        req = 1'b0; rekey = 1'b0; key_ack = 1'b0; seed_in = '0;
        req1 = 1'b0; rekey1 = 1'b0; key_ack1 = 1'b0; seed_in1 = '0;
        tick();
        tick();
        chk("rst_start", prng_start, 1'b0);
        chk("rst_new_key", prng_new_key, 1'b0);
        chk("rst_count_load", prng_count_load, 32'h0);
        chk("rst_key", key_out, 256'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", key_cnt, 8'h0);
        rst = 1'b0;

        // Unseeded first key
        k1 = exp_key(32'h1234_5678, 1);
        req = 1'b1;
        seed_in = 32'h1234_5678;
        watch(19, 1'b1, 32'h1234_5678, 3, 17, 256'h0);
        chk("key1", key_out, k1);

        // Consumer stalls for 50 cycles
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("hold_valid", key_valid, 1'b1);
            chk("hold_key", key_out, k1);
        end
        chk("hold_cnt", key_cnt, 8'd0);
        do_ack(8'd1);

        // Seeded second key continues the sequence
        k2 = exp_key(k1[255:224], 1);
        req = 1'b1;
        watch(17, 1'b0, 32'h0, 1, 15, k1);
        chk("key2", key_out, k2);
        do_ack(8'd2);

        // Reseed during the 4th capture
        kpart = exp_key(k2[255:224], 1);
        kstale = k2;
        kstale[95:0] = kpart[95:0];
        k3 = exp_key(32'hCAFE_BABE, 1);
        req = 1'b1;
        seed_in = 32'hCAFE_BABE;
        for (int c = 1; c <= 8; c++) begin
            tick();
            req = 1'b0;
        end
        rekey = 1'b1;
        watch(19, 1'b1, 32'hCAFE_BABE, 3, 17, kstale);
        chk("key3", key_out, k3);
        do_ack(8'd3);

        // All-zero seed is forced to 1
        k4 = exp_key(32'h1, 1);
        seed_in = 32'h0;
        rekey = 1'b1;
        req = 1'b1;
        watch(19, 1'b1, 32'h0000_0001, 3, 17, k3);
        chk("key4", key_out, k4);
        do_ack(8'd4);

        // SKIP=1 instance: two steps per captured word
        pulses = 0;
        req1 = 1'b1;
        seed_in1 = 32'hDEAD_BEEF;
        for (int c = 1; c <= 35; c++) begin
            tick();
            req1 = 1'b0;
            if (prng_new_key1) pulses++;
            chk("s1_start", prng_start1, c == 1);
            chk("s1_new_key", prng_new_key1, c >= 3 && c <= 33 && (c % 2 == 1));
            chk("s1_valid", key_valid1, c == 35);
        end
        chk("s1_pulses", pulses, 16);
        chk("s1_key", key_out1, exp_key(32'hDEAD_BEEF, 2));

        // rekey beats key_ack in the same VALID cycle
        rekey1 = 1'b1;
        key_ack1 = 1'b1;
        tick();
        rekey1 = 1'b0;
        key_ack1 = 1'b0;
        chk("s1_cnt", key_cnt1, 8'd0);
        chk("s1_valid_drop", key_valid1, 1'b0);
        chk("s1_reseed", prng_start1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
